// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: data width, ALU opcode encoding,
// the arbiter defaults and the marker value returned on an aborted operation.
package riscv_defines;

    localparam int DATA_WIDTH      = 32;
    localparam int ALU_ARB_TIMEOUT = 64;
    localparam int ALU_ARB_NREQ    = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    // Result delivered to a requester whose operation hit the watchdog.
    localparam logic [DATA_WIDTH-1:0] DEBUG_NO_USE = 32'hDEAD_BEEF;

endpackage

// File: rtl/alu_if.sv
// Request/response bundle between a requester and a multi-cycle ALU.
interface alu_if;
    import riscv_defines::*;

    logic                  req_valid;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    alu_op_t               alu_op;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] result;

    modport requester (
        output req_valid, operand1, operand2, alu_op,
        input  resp_valid, result
    );

    modport responder (
        input  req_valid, operand1, operand2, alu_op,
        output resp_valid, result
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester that was not granted last. The pointer moves only on a taken grant.
module rr_arbiter2
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ALU_ARB_NREQ-1:0] req_i,
    input  logic                    grant_en_i,
    output logic [ALU_ARB_NREQ-1:0] grant_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase

        last_grant_d = last_grant_q;
        if (grant_en_i && (grant_o != 2'b00)) begin
            last_grant_d = grant_o[1];
        end
    end

    // Reset points at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters: one operation in flight,
// round-robin on ties, and a watchdog that aborts an unanswered operation.
module alu_arbiter
    import riscv_defines::*;
#(
    parameter int TIMEOUT_CYCLES = ALU_ARB_TIMEOUT
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_if.responder  req0,
    alu_if.responder  req1,
    alu_if.requester  alu,
    output logic      timeout_err
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    arb_state_t            state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    alu_op_t               op_q, op_d;
    logic [DATA_WIDTH-1:0] res0_q, res0_d;
    logic [DATA_WIDTH-1:0] res1_q, res1_d;
    logic [1:0]            rvld_q, rvld_d;
    logic [WD_W-1:0]       wd_q, wd_d, wd_inc;
    logic                  to_q, to_d;

    logic [1:0] req_vec;
    logic [1:0] grant;
    logic       grant_en;

    assign req_vec = {req1.req_valid, req0.req_valid};

    rr_arbiter2 u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_vec),
        .grant_en_i (grant_en),
        .grant_o    (grant)
    );

    assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        op_d     = op_q;
        res0_d   = res0_q;
        res1_d   = res1_q;
        rvld_d   = 2'b00;
        wd_d     = wd_q;
        to_d     = 1'b0;
        grant_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    grant_en = 1'b1;
                    gnt_d    = grant[1];
                    op1_d    = grant[1] ? req1.operand1 : req0.operand1;
                    op2_d    = grant[1] ? req1.operand2 : req0.operand2;
                    op_d     = grant[1] ? req1.alu_op   : req0.alu_op;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (alu.resp_valid) begin
                    if (gnt_q) res1_d = alu.result;
                    else       res0_d = alu.result;
                    rvld_d  = gnt_q ? 2'b10 : 2'b01;
                    state_d = RESP;
                end else begin
                    wd_d = wd_inc;
                    // Abort when the counter is about to reach its last value,
                    // so RESP lands TIMEOUT_CYCLES cycles after ISSUE.
                    if (wd_inc == WD_LAST) begin
                        if (gnt_q) res1_d = DEBUG_NO_USE;
                        else       res0_d = DEBUG_NO_USE;
                        rvld_d  = gnt_q ? 2'b10 : 2'b01;
                        to_d    = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            op_q    <= ALU_ADD;
            res0_q  <= '0;
            res1_q  <= '0;
            rvld_q  <= 2'b00;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            op_q    <= op_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            rvld_q  <= rvld_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end

    assign alu.req_valid  = (state_q == ISSUE);
    assign alu.operand1   = op1_q;
    assign alu.operand2   = op2_q;
    assign alu.alu_op     = op_q;

    assign req0.resp_valid = rvld_q[0];
    assign req0.result     = res0_q;
    assign req1.resp_valid = rvld_q[1];
    assign req1.result     = res1_q;

    assign timeout_err = to_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push hand-computed
// responses into a queue that a negedge monitor drains as responses appear.
module tb_alu_arbiter;
    import riscv_defines::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_if r0();
    alu_if r1();
    alu_if a();
    logic timeout_err;

    logic        rv  [2];
    logic [31:0] o1  [2];
    logic [31:0] o2  [2];
    alu_op_t     opc [2];

    assign r0.req_valid = rv[0];
    assign r0.operand1  = o1[0];
    assign r0.operand2  = o2[0];
    assign r0.alu_op    = opc[0];
    assign r1.req_valid = rv[1];
    assign r1.operand1  = o1[1];
    assign r1.operand2  = o2[1];
    assign r1.alu_op    = opc[1];

    logic        stub_rv, stray_rv, never, pend;
    logic [31:0] stub_res, res_hold;
    int          stub_cnt;

    assign a.resp_valid = stub_rv | stray_rv;
    assign a.result     = stray_rv ? 32'hBAD0_BAD0 : stub_res;

    alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (r0),
        .req1        (r1),
        .alu         (a),
        .timeout_err (timeout_err)
    );

    function automatic logic [31:0] alu_stub(input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_XOR:  return x ^ y;
            ALU_OR:   return x | y;
            ALU_AND:  return x & y;
            ALU_SLT:  return 32'($signed(x) < $signed(y));
            ALU_SLTU: return 32'(x < y);
            ALU_SLL:  return x << y[4:0];
            ALU_SRL:  return x >> y[4:0];
            ALU_SRA:  return 32'($signed(x) >>> y[4:0]);
            default:  return 32'd0;
        endcase
    endfunction

    // Multi-cycle ALU stub: answers a few cycles after each issue unless 'never' is set.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_rv  <= 1'b0;
            pend     <= 1'b0;
            stub_cnt <= 0;
            stub_res <= 32'd0;
            res_hold <= 32'd0;
        end else begin
            stub_rv <= 1'b0;
            if (a.req_valid) begin
                pend     <= !never;
                stub_cnt <= 2;
                res_hold <= alu_stub(a.alu_op, a.operand1, a.operand2);
            end else if (pend) begin
                if (stub_cnt == 0) begin
                    stub_rv  <= 1'b1;
                    stub_res <= res_hold;
                    pend     <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    typedef struct {
        int          port;
        logic [31:0] res;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_issue = 0;
    int resp_seen = 0;
    int issue_cyc = 0;
    int alu_rv_cyc = 0;
    int resp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a.req_valid) begin
                n_issue++;
                issue_cyc = cyc;
            end
            if (a.resp_valid) alu_rv_cyc = cyc;
            if (r0.resp_valid || r1.resp_valid) begin
                resp_seen++;
                resp_cyc = cyc;
                chk("single_resp_valid", 32'(r0.resp_valid & r1.resp_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: actual resp0=%b resp1=%b required none", r0.resp_valid, r1.resp_valid);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("grant_port", 32'(r1.resp_valid), 32'(mon_e.port));
                    chk("result", r1.resp_valid ? r1.result : r0.result, mon_e.res);
                    chk("timeout_err", 32'(timeout_err), 32'(mon_e.to));
                end
            end else if (timeout_err) begin
                n_chk++;
                n_fail++;
                $display("FAIL stray_timeout_err: actual 1 required 0");
            end
        end
    end

    task automatic push_exp(input int p, input logic [31:0] r, input logic t);
        exp_t e;
        e.port = p;
        e.res  = r;
        e.to   = t;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int p, input alu_op_t o, input logic [31:0] x, input logic [31:0] y);
        rv[p]  = 1'b1;
        opc[p] = o;
        o1[p]  = x;
        o2[p]  = y;
    endtask

    task automatic wait_resp(input int p, input string name);
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (p == 0 ? r0.resp_valid : r1.resp_valid) got = 1;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: actual no response in 100 cycles required response", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(input string name);
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (a.req_valid) got = 1;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: actual no alu issue in 100 cycles required issue", name);
        end
    endtask

    task automatic drive(input int p, input alu_op_t o, input logic [31:0] x, input logic [31:0] y, input string name);
        set_req(p, o, x, y);
        wait_resp(p, name);
        rv[p] = 1'b0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_resp0"},   32'(r0.resp_valid), 32'd0);
        chk({pfx, "_resp1"},   32'(r1.resp_valid), 32'd0);
        chk({pfx, "_result0"}, r0.result, 32'd0);
        chk({pfx, "_result1"}, r1.result, 32'd0);
        chk({pfx, "_alu_req"}, 32'(a.req_valid), 32'd0);
        chk({pfx, "_alu_op1"}, a.operand1, 32'd0);
        chk({pfx, "_alu_op2"}, a.operand2, 32'd0);
        chk({pfx, "_alu_op"},  32'(a.alu_op), 32'd0);
        chk({pfx, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: actual simulation still running required finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int base;
        rv[0] = 1'b0;  rv[1] = 1'b0;
        o1[0] = 32'd0; o1[1] = 32'd0;
        o2[0] = 32'd0; o2[1] = 32'd0;
        opc[0] = ALU_ADD; opc[1] = ALU_ADD;
        stray_rv = 1'b0;
        never    = 1'b0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie straight after reset: req0 first, then req1.
        base = n_issue;
        push_exp(0, 32'd7, 1'b0);
        push_exp(1, 32'hFF, 1'b0);
        fork
            drive(0, ALU_SUB, 32'd10, 32'd3, "tie_req0");
            drive(1, ALU_XOR, 32'hF0, 32'h0F, "tie_req1");
        join
        chk("tie_issue_pulses", 32'(n_issue - base), 32'd2);

        // Continuous contention alternates 0,1,0,1.
        base = n_issue;
        push_exp(0, 32'd3, 1'b0);
        push_exp(1, 32'h0000_0FF0, 1'b0);
        push_exp(0, 32'd5, 1'b0);
        push_exp(1, 32'h0F00_0F00, 1'b0);
        fork
            begin
                drive(0, ALU_ADD, 32'd1, 32'd2, "rr_req0_a");
                drive(0, ALU_SUB, 32'd9, 32'd4, "rr_req0_b");
            end
            begin
                drive(1, ALU_OR,  32'h0000_0F00, 32'h0000_00F0, "rr_req1_a");
                drive(1, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, "rr_req1_b");
            end
        join
        chk("rr_issue_pulses", 32'(n_issue - base), 32'd4);

        // Lone req0 ADD.
        base = n_issue;
        push_exp(0, 32'd12, 1'b0);
        drive(0, ALU_ADD, 32'd5, 32'd7, "add_req0");
        chk("add_issue_pulses", 32'(n_issue - base), 32'd1);
        chk("add_resp_latency", 32'(resp_cyc - alu_rv_cyc), 32'd1);

        // req1 withdraws after grant; the result is still delivered.
        push_exp(1, 32'd1, 1'b0);
        set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        wait_issue("slt_issue");
        @(posedge clk);
        #1;
        rv[1] = 1'b0;
        wait_resp(1, "slt_req1");

        base = resp_seen;
        stray_rv = 1'b1;
        @(posedge clk);
        #1;
        stray_rv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_stray_ignored", 32'(resp_seen - base), 32'd0);
        chk("req1_result_hold", r1.result, 32'd1);

        // ALU never answers: watchdog abort.
        never = 1'b1;
        push_exp(0, DEBUG_NO_USE, 1'b1);
        drive(0, ALU_ADD, 32'd1, 32'd1, "timeout_req0");
        chk("timeout_resp_after_issue", 32'(resp_cyc - issue_cyc), 32'd8);
        chk("timeout_result_hold", r0.result, DEBUG_NO_USE);
        chk("req1_result_hold_2", r1.result, 32'd1);

        // Reset while waiting on the ALU, then a stray ALU response.
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        wait_issue("rst_issue");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("midop_reset");
        rv[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        base = resp_seen;
        @(posedge clk);
        #1;
        stray_rv = 1'b1;
        @(posedge clk);
        #1;
        stray_rv = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_no_resp", 32'(resp_seen - base), 32'd0);
        chk_zero("post_reset");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
